// File: rtl/leibniz_pi_engine.sv
// Fixed-point Leibniz-series pi accumulator built around one shared iterative restoring divider.
// Optional PI_AVG_EN: pi_out reports the average of the last two partial sums.
module leibniz_pi_engine #(
    parameter int unsigned FRAC_BITS = 48,
    parameter int unsigned INT_BITS  = 4,
    parameter int unsigned NUM       = 4,
    parameter int unsigned NTERMS_W  = 16
) (
    input  logic                          clk_2,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NTERMS_W-1:0]           n_terms,
    output logic                          busy,
    output logic                          done,
    output logic [INT_BITS+FRAC_BITS-1:0] pi_out,
    output logic [NTERMS_W-1:0]           term_idx,
    output logic [NTERMS_W:0]             den_out
);

    localparam int unsigned ACC_W = INT_BITS + FRAC_BITS;
    localparam int unsigned REM_W = ACC_W + 1;
    localparam int unsigned DEN_W = NTERMS_W + 1;
    localparam int unsigned CMP_W = (REM_W + 1 > DEN_W) ? REM_W + 1 : DEN_W;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam logic [ACC_W-1:0] DIVIDEND = ACC_W'(NUM) << FRAC_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_ACC,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [NTERMS_W-1:0]  nlat_q;
    logic [REM_W-1:0]     rem_q;
    logic [ACC_W-1:0]     qsr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ACC_W-1:0]     sum_q;
    logic [DEN_W-1:0]     den_q;
    logic [NTERMS_W-1:0]  term_q;
    logic                 busy_q;
    logic                 done_q;

    logic [CMP_W-1:0]     shift_ext;
    logic [CMP_W-1:0]     den_ext;
    logic                 qbit_d;
    logic [REM_W-1:0]     rem_d;
    logic [ACC_W-1:0]     qsr_d;
    logic [CNT_W-1:0]     cnt_d;
    logic [ACC_W-1:0]     sum_d;
    logic [NTERMS_W-1:0]  term_d;

`ifdef PI_AVG_EN
    logic [ACC_W-1:0]     pi_q;
    logic [REM_W-1:0]     pair_sum;
    logic [ACC_W-1:0]     pi_d;
`endif

    // qsr shifts dividend bits out of the top while quotient bits fill from the bottom.
    always_comb begin
        shift_ext = CMP_W'({rem_q, qsr_q[ACC_W-1]});
        den_ext   = CMP_W'(den_q);
        qbit_d    = (shift_ext >= den_ext);
        rem_d     = qbit_d ? REM_W'(shift_ext - den_ext) : REM_W'(shift_ext);
        qsr_d     = {qsr_q[ACC_W-2:0], qbit_d};
        cnt_d     = cnt_q - CNT_W'(1);
        sum_d     = term_q[0] ? (sum_q - qsr_q) : (sum_q + qsr_q);
        term_d    = term_q + NTERMS_W'(1);
    end

`ifdef PI_AVG_EN
    // sum_q still holds S_{k-1} while S_k is being formed in ACC.
    always_comb begin
        pair_sum = REM_W'(sum_d) + REM_W'(sum_q);
        pi_d     = (term_d >= NTERMS_W'(2)) ? pair_sum[REM_W-1:1] : sum_d;
    end
`endif

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            nlat_q  <= '0;
            rem_q   <= '0;
            qsr_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            den_q   <= DEN_W'(1);
            term_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PI_AVG_EN
            pi_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        nlat_q  <= n_terms;
                        sum_q   <= '0;
                        term_q  <= '0;
                        den_q   <= DEN_W'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_LOAD;
`ifdef PI_AVG_EN
                        pi_q    <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (nlat_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        rem_q   <= '0;
                        qsr_q   <= DIVIDEND;
                        cnt_q   <= CNT_W'(ACC_W);
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    qsr_q <= qsr_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    // A zero quotient means further terms cannot change the sum.
                    if (qsr_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        sum_q  <= sum_d;
                        term_q <= term_d;
                        den_q  <= den_q + DEN_W'(2);
`ifdef PI_AVG_EN
                        pi_q   <= pi_d;
`endif
                        if (term_d == nlat_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign term_idx = term_q;
    assign den_out  = den_q;
`ifdef PI_AVG_EN
    assign pi_out   = pi_q;
`else
    assign pi_out   = sum_q;
`endif

endmodule

// File: tb/tb_leibniz_pi_engine.sv
// Directed self-checking bench for leibniz_pi_engine at FRAC_BITS=8, INT_BITS=4 (dividend 1024).
// Honours PI_AVG_EN when the same macro is defined for the bench.
module tb_leibniz_pi_engine;

    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned INT_BITS  = 4;
    localparam int unsigned NTERMS_W  = 16;
    localparam int unsigned ACC_W     = FRAC_BITS + INT_BITS;

`ifdef PI_AVG_EN
    localparam int unsigned EXP_N2 = 853;
    localparam int unsigned EXP_N3 = 785;
    localparam int unsigned EXP_N4 = 814;
`else
    localparam int unsigned EXP_N2 = 683;
    localparam int unsigned EXP_N3 = 887;
    localparam int unsigned EXP_N4 = 741;
`endif

    logic                 clk_2 = 1'b0;
    logic                 reset;
    logic                 start;
    logic [NTERMS_W-1:0]  n_terms;
    logic                 busy;
    logic                 done;
    logic [ACC_W-1:0]     pi_out;
    logic [NTERMS_W-1:0]  term_idx;
    logic [NTERMS_W:0]    den_out;

    int checks   = 0;
    int failures = 0;

    leibniz_pi_engine #(
        .FRAC_BITS (FRAC_BITS),
        .INT_BITS  (INT_BITS),
        .NUM       (4),
        .NTERMS_W  (NTERMS_W)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .start    (start),
        .n_terms  (n_terms),
        .busy     (busy),
        .done     (done),
        .pi_out   (pi_out),
        .term_idx (term_idx),
        .den_out  (den_out)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    // Leaves the bench 1 time unit after the accept edge (edge 0).
    task automatic start_job(input int unsigned n);
        start   = 1'b1;
        n_terms = NTERMS_W'(n);
        tick(1);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("done_within_budget", {63'd0, done}, 64'd1);
    endtask

    // Reference Leibniz sum using plain integer division of 1024 by 2k+1.
    task automatic model_run(input int unsigned n, output int unsigned pi_exp,
                             output int unsigned t_exp, output int unsigned den_exp);
        int unsigned s  = 0;
        int unsigned sp = 0;
        int unsigned q;
        int unsigned t  = 0;
        int unsigned d  = 1;
        while (t < n) begin
            q = 1024 / d;
            if (q == 0) break;
            sp = s;
            s  = (t % 2 == 0) ? s + q : s - q;
            t++;
            d += 2;
        end
        pi_exp = s;
`ifdef PI_AVG_EN
        if (t >= 2) pi_exp = (s + sp) / 2;
`endif
        t_exp   = t;
        den_exp = d;
    endtask

    initial begin
        int unsigned m_pi, m_t, m_den;

        reset   = 1'b0;
        start   = 1'b0;
        n_terms = '0;
        tick(3);
        check_eq("rst_pi",   64'(pi_out),   64'd0);
        check_eq("rst_term", 64'(term_idx), 64'd0);
        check_eq("rst_den",  64'(den_out),  64'd1);
        check_eq("rst_busy", 64'(busy),     64'd0);
        check_eq("rst_done", 64'(done),     64'd0);
        reset = 1'b1;
        tick(2);

        // n_terms = 1: done after edge 14
        start_job(1);
        check_eq("n1_busy_e0", 64'(busy), 64'd1);
        check_eq("n1_done_e0", 64'(done), 64'd0);
        tick(13);
        check_eq("n1_done_e13", 64'(done), 64'd0);
        tick(1);
        check_eq("n1_done_e14", 64'(done),     64'd1);
        check_eq("n1_busy_e14", 64'(busy),     64'd0);
        check_eq("n1_pi",       64'(pi_out),   64'd1024);
        check_eq("n1_term",     64'(term_idx), 64'd1);
        check_eq("n1_den",      64'(den_out),  64'd3);

        // n_terms = 2, restarted from DONE
        start_job(2);
        check_eq("n2_done_clr", 64'(done), 64'd0);
        tick(27);
        check_eq("n2_done_e27", 64'(done), 64'd0);
        tick(1);
        check_eq("n2_done_e28", 64'(done),   64'd1);
        check_eq("n2_pi",       64'(pi_out), 64'(EXP_N2));

        // n_terms = 4, then a fresh n_terms = 1 run
        start_job(4);
        tick(55);
        check_eq("n4_done_e55", 64'(done), 64'd0);
        tick(1);
        check_eq("n4_done_e56", 64'(done),     64'd1);
        check_eq("n4_pi",       64'(pi_out),   64'(EXP_N4));
        check_eq("n4_term",     64'(term_idx), 64'd4);
        start_job(1);
        tick(14);
        check_eq("rerun_done", 64'(done),   64'd1);
        check_eq("rerun_pi",   64'(pi_out), 64'd1024);

        // n_terms = 0
        start_job(0);
        tick(1);
        check_eq("n0_done", 64'(done),     64'd1);
        check_eq("n0_pi",   64'(pi_out),   64'd0);
        check_eq("n0_term", 64'(term_idx), 64'd0);

        // n_terms = 3 with a stray start at edge 5
        start_job(3);
        tick(4);
        start   = 1'b1;
        n_terms = NTERMS_W'(7);
        tick(1);
        start   = 1'b0;
        check_eq("n3_busy_e5", 64'(busy), 64'd1);
        tick(36);
        check_eq("n3_done_e41", 64'(done), 64'd0);
        tick(1);
        check_eq("n3_done_e42", 64'(done),     64'd1);
        check_eq("n3_term",     64'(term_idx), 64'd3);
        check_eq("n3_den",      64'(den_out),  64'd7);
        check_eq("n3_pi",       64'(pi_out),   64'(EXP_N3));
        model_run(3, m_pi, m_t, m_den);
        check_eq("n3_pi_model", 64'(pi_out), 64'(m_pi));

        // n_terms = all-ones stops on the zero-quotient rule
        start_job(65535);
        wait_done(8000);
        model_run(65535, m_pi, m_t, m_den);
        check_eq("nmax_term",  64'(term_idx), 64'd512);
        check_eq("nmax_den",   64'(den_out),  64'd1025);
        check_eq("nmax_pi",    64'(pi_out),   64'(m_pi));
        check_eq("nmax_tmod",  64'(term_idx), 64'(m_t));

        // asynchronous reset in the middle of term 2's division
        start_job(4);
        tick(20);
        check_eq("abort_busy_pre", 64'(busy),     64'd1);
        check_eq("abort_term_pre", 64'(term_idx), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_pi",   64'(pi_out),   64'd0);
        check_eq("abort_term", 64'(term_idx), 64'd0);
        check_eq("abort_den",  64'(den_out),  64'd1);
        check_eq("abort_busy", 64'(busy),     64'd0);
        check_eq("abort_done", 64'(done),     64'd0);
        tick(2);
        reset = 1'b1;
        tick(3);
        check_eq("post_busy", 64'(busy),     64'd0);
        check_eq("post_done", 64'(done),     64'd0);
        check_eq("post_term", 64'(term_idx), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
